// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and its line filters.
//   ps2_state_e   : transmitter FSM states
//   ps2_dbg_t     : debug view of the transmitter (state, bit index, line levels)
//   PARITY_IDX    : frame position of the odd-parity bit
//   STOP_IDX      : frame position of the stop bit
//   IDX_MAX       : saturation value of the frame bit index
//   inh_cycles()  : clock-inhibit length in system clock cycles
//   to_cycles()   : inter-edge timeout in system clock cycles
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    typedef struct packed {
        ps2_state_e  state;
        logic [3:0]  bit_idx;
        logic        clk_f;
        logic        data_f;
        logic        clk_fall;
        logic        data_fall;
    } ps2_dbg_t;

    localparam int PARITY_IDX = 8;
    localparam int STOP_IDX   = 9;
    localparam int IDX_MAX    = 10;

    // Frequency is divided first so the product stays inside 32 bits.
    function automatic int us_to_cycles(input int clk_freq, input int us);
        return (clk_freq / 1_000_000) * us;
    endfunction

    function automatic int inh_cycles(input int clk_freq, input int inhibit_us);
        return us_to_cycles(clk_freq, inhibit_us);
    endfunction

    function automatic int to_cycles(input int clk_freq, input int timeout_us);
        return us_to_cycles(clk_freq, timeout_us);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pad level: 2-FF synchroniser, debounce, fall pulse.
//   clk    in  system clock
//   reset  in  asynchronous, active-low reset
//   raw    in  raw (asynchronous) pad level
//   level  out debounced level; changes only after FILTER_LEN identical
//              synchronised samples that differ from the current level
//   fall   out one-cycle pulse in the cycle level goes 1 -> 0
// An idle PS/2 line is pulled high, so every stage resets to 1.
// -----------------------------------------------------------------------------
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            fall  <= 1'b0;
            // run_cnt counts consecutive samples that disagree with level;
            // any agreeing sample restarts the run, so short glitches vanish.
            if (sync2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync2;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED LED-set)
// over the shared open-drain ps2_clk/ps2_data lines.
//   clk          in  system clock
//   reset        in  asynchronous, active-low reset
//   tx_data      in  byte to send, LSB first
//   tx_valid     in  transfer request
//   tx_ready     out high only in IDLE
//   tx_busy      out high in every state except IDLE (receiver ignores frames)
//   tx_done      out one-cycle pulse: device acknowledged the byte
//   tx_err       out one-cycle pulse: timeout or missing ACK
//   ps2_clk_in   in  raw ps2_clk pad level
//   ps2_data_in  in  raw ps2_data pad level
//   ps2_clk_oe   out 1 = pull ps2_clk low
//   ps2_data_oe  out 1 = pull ps2_data low
//   dbg          out FSM state, bit index and filtered line view
// Handshake: a byte is accepted in the cycle tx_valid && tx_ready is seen at
// the clock edge; tx_valid is ignored whenever tx_ready is low (no queueing).
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output ps2_dbg_t   dbg
);

    localparam int INH = inh_cycles(CLK_FREQ, INHIBIT_US);
    localparam int TO  = to_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int CW  = $clog2(((INH > TO) ? INH : TO) + 1);

    logic clk_f, clk_fall;
    logic data_f, data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_f),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_f),
        .fall  (data_fall)
    );

    ps2_state_e    state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    idx_q, idx_n;
    logic [9:0]    frame_q, frame_n;
    logic [3:0]    idx_inc;
    logic          clk_oe_c, data_oe_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            frame_q <= frame_n;
        end
    end

    assign idx_inc = (idx_q == 4'(IDX_MAX)) ? idx_q : idx_q + 4'd1;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        frame_n   = frame_q;
        clk_oe_c  = 1'b0;
        data_oe_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    // {stop, odd parity, data}; bit 0 goes out first.
                    frame_n = {1'b1, ~^tx_data, tx_data};
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                // Host priority: the clock is forced low regardless of what the
                // device is doing; device falls seen here are ignored.
                clk_oe_c = 1'b1;
                if (cnt_q == CW'(INH - 1)) begin
                    data_oe_c = 1'b1;          // start bit set up before release
                    cnt_n     = '0;
                    state_n   = RTS;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            RTS: begin
                data_oe_c = 1'b1;
                if (clk_fall) begin
                    idx_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // idx only moves on a fall, so data_oe changes in the cycle
                // after a fall and stays put for the rest of the bit.
                data_oe_c = ~frame_q[idx_q];
                if (clk_fall) begin
                    idx_n = idx_inc;
                    if (idx_inc == 4'(STOP_IDX)) begin
                        state_n = ACK;         // stop bit = released line
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    state_n = data_f ? ERR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Further device falls here only restart the timeout.
                if (clk_f && data_f) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Shared inter-edge timeout for every state that waits on the device.
        if (state_q == RTS || state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
            if (clk_fall) begin
                cnt_n = '0;
            end else begin
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(TO - 1)) begin
                    state_n = ERR;
                end
            end
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign tx_done     = (state_q == DONE);
    assign tx_err      = (state_q == ERR);
    assign ps2_clk_oe  = clk_oe_c;
    assign ps2_data_oe = data_oe_c;

    assign dbg = '{state:     state_q,
                   bit_idx:   idx_q,
                   clk_f:     clk_f,
                   data_f:    data_f,
                   clk_fall:  clk_fall,
                   data_fall: data_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_US = 2000;
    localparam int FILTER_LEN = 8;
    localparam int HALF       = 25;     // device clock half period, cycles (1 us each)
    localparam int EXP_INH    = 100;
    localparam int EXP_TO     = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    ps2_dbg_t   dbg;

    // open-drain bus: either side may pull a line low
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .dbg         (dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- output monitors ----------------
    int   done_hi = 0, done_rise = 0, err_hi = 0, err_rise = 0, err_oe_bad = 0;
    int   inh_run = 0, inh_len = 0, inh_data_at = 0, inh_starts = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    bit   inh_data_seen = 1'b0;

    always @(negedge clk) begin
        if (tx_done) done_hi++;
        if (tx_done && !done_prev) done_rise++;
        done_prev = tx_done;
        if (tx_err) err_hi++;
        if (tx_err && !err_prev) err_rise++;
        err_prev = tx_err;
        if (tx_err && (ps2_clk_oe || ps2_data_oe)) err_oe_bad++;
        if (ps2_clk_oe) begin
            if (inh_run == 0) inh_starts++;
            inh_run++;
            if (ps2_data_oe && !inh_data_seen) begin
                inh_data_seen = 1'b1;
                inh_data_at   = inh_run;
            end
        end else begin
            if (inh_run > 0) inh_len = inh_run;
            inh_run       = 0;
            inh_data_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
        end
    endtask

    task automatic bfm_wait_rts(output bit ok);
        bit inh;
        inh = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 200 && !inh; i++) begin
            @(negedge clk);
            if (!ps2_clk_in) inh = 1'b1;
        end
        for (int i = 0; i < 400 && inh && !ok; i++) begin
            @(negedge clk);
            if (ps2_clk_in && !ps2_data_in) ok = 1'b1;
        end
    endtask

    // One device clock: low phase, sample data on the rising edge, optionally
    // pull data afterwards, high phase (with an optional 3-cycle low glitch).
    task automatic dev_clock(input bit glitch, input bit pull, output logic sample);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        sample       = ps2_data_in;
        dev_data_low = pull;
        if (glitch) begin
            repeat (8) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF - 11) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic bfm_frame(input bit ack_low, input int glitch_bit,
                             output logic [9:0] rx, output bit ok);
        logic s;
        rx = '0;
        bfm_wait_rts(ok);
        if (ok) begin
            repeat (20) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                dev_clock(i == glitch_bit, (i == 9) ? ack_low : 1'b0, s);
                rx[i] = s;
            end
            dev_clock(1'b0, 1'b0, s);   // ACK clock, data released after it
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         glitch_bit;
        bit         junk_req;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rx;
        logic [9:0] exp;
        bit   ok, okr, found;
        int   d0, e0, i0, k;

        vecs[0] = '{data: 8'hED, ack: 1'b1, glitch_bit: -1, junk_req: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'h07, ack: 1'b1, glitch_bit: -1, junk_req: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{data: 8'h00, ack: 1'b1, glitch_bit: -1, junk_req: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'hA5, ack: 1'b0, glitch_bit: -1, junk_req: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{data: 8'h3C, ack: 1'b1, glitch_bit: 3,  junk_req: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

        // reset state
        repeat (5) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // table-driven transfers
        for (int v = 0; v < 5; v++) begin
            d0 = done_rise; e0 = err_rise; i0 = inh_starts;
            exp_q.push_back({1'b1, ~^vecs[v].data, vecs[v].data});
            send(vecs[v].data);
            check($sformatf("v%0d_ready_low", v), 32'(tx_ready), 32'd0);
            check($sformatf("v%0d_clk_oe", v), 32'(ps2_clk_oe), 32'd1);
            if (vecs[v].junk_req) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                repeat (3) @(negedge clk);
                tx_valid = 1'b0;
            end
            bfm_frame(vecs[v].ack, vecs[v].glitch_bit, rx, ok);
            check($sformatf("v%0d_rts_seen", v), 32'(ok), 32'd1);
            exp = exp_q.pop_front();
            check($sformatf("v%0d_frame", v), 32'(rx), 32'(exp));
            wait_ready(300, okr);
            check($sformatf("v%0d_back_idle", v), 32'(okr), 32'd1);
            repeat (200) @(negedge clk);
            check($sformatf("v%0d_done_pulses", v), 32'(done_rise - d0), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_err_pulses", v), 32'(err_rise - e0), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_inh_len", v), 32'(inh_len), 32'(EXP_INH));
            check($sformatf("v%0d_inh_start_bit", v), 32'(inh_data_at), 32'(EXP_INH));
            check($sformatf("v%0d_one_request", v), 32'(inh_starts - i0), 32'd1);
            check($sformatf("v%0d_oe_released", v), 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        end

        // device never clocks after RTS: timeout
        d0 = done_rise; e0 = err_rise;
        send(8'h12);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (dbg.state == RTS) found = 1'b1;
        end
        check("to_rts_reached", 32'(found), 32'd1);
        k = 0;
        while (!tx_err && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("to_cycles", 32'(k), 32'(EXP_TO));
        check("to_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (5) @(negedge clk);
        check("to_err_pulse", 32'(err_rise - e0), 32'd1);
        check("to_no_done", 32'(done_rise - d0), 32'd0);

        // asynchronous reset during SHIFT bit 4
        d0 = done_rise; e0 = err_rise;
        send(8'h4A);
        bfm_wait_rts(ok);
        check("rs_rts_seen", 32'(ok), 32'd1);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            logic s;
            dev_clock(1'b0, 1'b0, s);
        end
        check("rs_in_shift", 32'(dbg.state), 32'(SHIFT));
        check("rs_bit_idx", 32'(dbg.bit_idx), 32'd4);
        check("rs_data_oe_bit4", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rs_async_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rs_async_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("rs_no_pulses", 32'((done_rise - d0) + (err_rise - e0)), 32'd0);
        exp_q.push_back({1'b1, ~^8'h4A, 8'h4A});
        send(8'h4A);
        check("rs_fresh_inhibit", 32'(dbg.state), 32'(INHIBIT));
        bfm_frame(1'b1, -1, rx, ok);
        exp = exp_q.pop_front();
        check("rs_fresh_frame", 32'(rx), 32'(exp));
        wait_ready(300, okr);
        repeat (5) @(negedge clk);
        check("rs_fresh_done", 32'(done_rise - d0), 32'd1);
        check("rs_fresh_inh_len", 32'(inh_len), 32'(EXP_INH));

        // global pulse-shape checks
        check("done_one_cycle", 32'(done_hi), 32'(done_rise));
        check("err_one_cycle", 32'(err_hi), 32'(err_rise));
        check("err_lines_released", 32'(err_oe_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
